// File: rtl/maze_dfs_generator_if.sv
// Start/read handshake shared by the game controller, the maze generator and the VGA renderer.
// Defining MAZE_STATS_EN adds the max_depth/step_count statistics outputs.
interface maze_dfs_generator_if #(
  parameter int XW  = 5,
  parameter int YW  = 4,
  parameter int SPW = 10
);
  logic          start;
  logic [XW-1:0] start_x;
  logic [YW-1:0] start_y;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [1:0]    rd_data;
  logic          rd_valid;
`ifdef MAZE_STATS_EN
  logic [SPW-1:0] max_depth;
  logic [31:0]    step_count;

  modport master (output start, start_x, start_y, rd_en, rd_x, rd_y,
                  input  busy, done, rd_data, rd_valid, max_depth, step_count);
  modport slave  (input  start, start_x, start_y, rd_en, rd_x, rd_y,
                  output busy, done, rd_data, rd_valid, max_depth, step_count);
`else
  modport master (output start, start_x, start_y, rd_en, rd_x, rd_y,
                  input  busy, done, rd_data, rd_valid);
  modport slave  (input  start, start_x, start_y, rd_en, rd_x, rd_y,
                  output busy, done, rd_data, rd_valid);
`endif
endinterface

// File: rtl/maze_dfs_generator.sv
// Recursive-backtracker maze generator: hardware stack, visited flops, Galois LFSR directions.
// Defining MAZE_STATS_EN adds peak stack depth and PROBE/CARVE/POP cycle counters.
module maze_dfs_generator #(
  parameter int          CELLS_X = 32,
  parameter int          CELLS_Y = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          XW      = (CELLS_X > 1) ? $clog2(CELLS_X) : 1,
  parameter int          YW      = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1,
  parameter int          SPW     = $clog2(CELLS_X * CELLS_Y + 1)
) (
  input  logic clk,
  input  logic reset,
  maze_dfs_generator_if.slave bus
);

  localparam int          NCELLS   = CELLS_X * CELLS_Y;
  localparam int          CW       = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {IDLE, CLEAR, INIT, PROBE, CARVE, POP, DONE} state_e;

  state_e            state_q, state_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [CW-1:0]     clrIdx_q, clrIdx_d;
  logic [XW-1:0]     startX_q, startX_d;
  logic [YW-1:0]     startY_q, startY_d;
  logic [NCELLS-1:0] visited_q, visited_d;
  logic [NCELLS-1:0] east_q, east_d;
  logic [NCELLS-1:0] south_q, south_d;
  logic [XW+YW-1:0]  stack_q [NCELLS];
  logic [1:0]        rdData_q, rdData_d;
  logic              rdValid_q;

  logic             busy, startAcc, pushEn, initInRange, rdOk;
  logic [XW+YW-1:0] pushVal, topEntry;
  logic [SPW-1:0]   topPtr;
  logic [XW-1:0]    curX, nbrX, initX;
  logic [YW-1:0]    curY, nbrY, initY;
  logic [CW-1:0]    curIdx, nbrIdx, initIdx, rdIdx;
  logic [3:0]       mask;
  logic [1:0]       dir;

  assign busy     = state_q inside {CLEAR, INIT, PROBE, CARVE, POP};
  assign startAcc = bus.start && (state_q == IDLE || state_q == DONE);

  assign topPtr   = sp_q - SPW'(1);
  assign topEntry = (sp_q != '0) ? stack_q[topPtr] : '0;
  assign curX     = topEntry[XW-1:0];
  assign curY     = topEntry[XW+YW-1:XW];
  assign curIdx   = CW'(curY) * CW'(CELLS_X) + CW'(curX);

  assign initInRange = ({1'b0, startX_q} < (XW+1)'(CELLS_X)) && ({1'b0, startY_q} < (YW+1)'(CELLS_Y));
  assign initX       = initInRange ? startX_q : '0;
  assign initY       = initInRange ? startY_q : '0;
  assign initIdx     = CW'(initY) * CW'(CELLS_X) + CW'(initX);

  // Mask bit order is {up, down, left, right}; edge cells never see an out-of-grid neighbour.
  always_comb begin
    mask = '0;
    if (curX != XW'(CELLS_X - 1)) mask[0] = !visited_q[curIdx + CW'(1)];
    if (curX != '0)               mask[1] = !visited_q[curIdx - CW'(1)];
    if (curY != YW'(CELLS_Y - 1)) mask[2] = !visited_q[curIdx + CW'(CELLS_X)];
    if (curY != '0)               mask[3] = !visited_q[curIdx - CW'(CELLS_X)];
  end

  always_comb begin
    dir = lfsr_q[1:0];
    for (int k = 3; k >= 0; k--) begin
      if (mask[lfsr_q[1:0] + 2'(k)]) dir = lfsr_q[1:0] + 2'(k);
    end
  end

  always_comb begin
    nbrX   = curX;
    nbrY   = curY;
    nbrIdx = curIdx;
    case (dir)
      2'd0:    begin nbrX = curX + XW'(1); nbrIdx = curIdx + CW'(1); end
      2'd1:    begin nbrX = curX - XW'(1); nbrIdx = curIdx - CW'(1); end
      2'd2:    begin nbrY = curY + YW'(1); nbrIdx = curIdx + CW'(CELLS_X); end
      default: begin nbrY = curY - YW'(1); nbrIdx = curIdx - CW'(CELLS_X); end
    endcase
  end

  // Left/up carves open the neighbour's wall, since each cell only stores its east and south sides.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lfsr_d    = lfsr_q;
    clrIdx_d  = clrIdx_q;
    startX_d  = startX_q;
    startY_d  = startY_q;
    visited_d = visited_q;
    east_d    = east_q;
    south_d   = south_q;
    pushEn    = 1'b0;
    pushVal   = '0;
    if (busy) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = CLEAR;
          clrIdx_d = '0;
          startX_d = bus.start_x;
          startY_d = bus.start_y;
        end
      end
      CLEAR: begin
        visited_d[clrIdx_q] = 1'b0;
        east_d[clrIdx_q]    = 1'b0;
        south_d[clrIdx_q]   = 1'b0;
        if (clrIdx_q == CW'(NCELLS - 1)) state_d = INIT;
        else clrIdx_d = clrIdx_q + CW'(1);
      end
      INIT: begin
        visited_d[initIdx] = 1'b1;
        pushEn  = 1'b1;
        pushVal = {initY, initX};
        sp_d    = SPW'(1);
        state_d = PROBE;
      end
      PROBE: state_d = (mask != 4'b0000) ? CARVE : POP;
      CARVE: begin
        case (dir)
          2'd0:    east_d[curIdx]  = 1'b1;
          2'd1:    east_d[nbrIdx]  = 1'b1;
          2'd2:    south_d[curIdx] = 1'b1;
          default: south_d[nbrIdx] = 1'b1;
        endcase
        visited_d[nbrIdx] = 1'b1;
        pushEn  = 1'b1;
        pushVal = {nbrY, nbrX};
        sp_d    = sp_q + SPW'(1);
        state_d = PROBE;
      end
      POP: begin
        sp_d    = sp_q - SPW'(1);
        state_d = (sp_q == SPW'(1)) ? DONE : PROBE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdOk  = bus.rd_en && !busy &&
                 ({1'b0, bus.rd_x} < (XW+1)'(CELLS_X)) && ({1'b0, bus.rd_y} < (YW+1)'(CELLS_Y));
  assign rdIdx = CW'(bus.rd_y) * CW'(CELLS_X) + CW'(bus.rd_x);

  always_comb begin
    rdData_d = 2'b00;
    if (rdOk) rdData_d = {east_q[rdIdx], south_q[rdIdx]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      lfsr_q    <= SEED_EFF;
      clrIdx_q  <= '0;
      startX_q  <= '0;
      startY_q  <= '0;
      visited_q <= '0;
      east_q    <= '0;
      south_q   <= '0;
      rdData_q  <= 2'b00;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      lfsr_q    <= lfsr_d;
      clrIdx_q  <= clrIdx_d;
      startX_q  <= startX_d;
      startY_q  <= startY_d;
      visited_q <= visited_d;
      east_q    <= east_d;
      south_q   <= south_d;
      rdData_q  <= rdData_d;
      rdValid_q <= bus.rd_en;
    end
  end

  // Stack RAM needs no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (!reset && pushEn) begin
      assert (sp_q < SPW'(NCELLS));
      stack_q[sp_q] <= pushVal;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state_q == DONE);
  assign bus.rd_data  = rdData_q;
  assign bus.rd_valid = rdValid_q;

`ifdef MAZE_STATS_EN
  logic [SPW-1:0] maxDepth_q, maxDepth_d;
  logic [31:0]    stepCount_q, stepCount_d;

  always_comb begin
    maxDepth_d  = maxDepth_q;
    stepCount_d = stepCount_q;
    if (startAcc) begin
      maxDepth_d  = '0;
      stepCount_d = '0;
    end else begin
      if (state_q inside {PROBE, CARVE, POP}) stepCount_d = stepCount_q + 32'd1;
      if (sp_d > maxDepth_q) maxDepth_d = sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      maxDepth_q  <= '0;
      stepCount_q <= '0;
    end else begin
      maxDepth_q  <= maxDepth_d;
      stepCount_q <= stepCount_d;
    end
  end

  assign bus.max_depth  = maxDepth_q;
  assign bus.step_count = stepCount_q;
`else
  logic unusedStart;
  assign unusedStart = startAcc;
`endif

endmodule

// File: tb/tb_maze_dfs_generator.sv
// Directed bench for maze_dfs_generator on 4x4, 1x1 and 8x8 grids with a reference DFS model.
// Statistics outputs are checked only when MAZE_STATS_EN is defined.
module tb_maze_dfs_generator;

  logic clk = 1'b0;
  logic reset;
  int   sel;
  logic start, rdEn;
  logic [2:0] sx, sy, rx, ry;
  logic busyS, doneS, rdValidS;
  logic [1:0] rdDataS;
  int nChecks = 0;
  int nErrors = 0;
  logic [63:0] gotE, gotS, expE, expS, saveE, saveS;
  logic [15:0] mdlL [3];
  int expCyc, expSteps, expMax, cyc;
  logic [1:0] d;
  logic v;

  always #5 clk = ~clk;

  maze_dfs_generator_if #(.XW(2), .YW(2), .SPW(5)) if4 ();
  maze_dfs_generator_if #(.XW(1), .YW(1), .SPW(1)) if1 ();
  maze_dfs_generator_if #(.XW(3), .YW(3), .SPW(7)) if8 ();

  maze_dfs_generator #(.CELLS_X(4), .CELLS_Y(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  maze_dfs_generator #(.CELLS_X(1), .CELLS_Y(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  maze_dfs_generator #(.CELLS_X(8), .CELLS_Y(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  assign if4.start = start && (sel == 0);
  assign if4.start_x = sx[1:0];
  assign if4.start_y = sy[1:0];
  assign if4.rd_en = rdEn && (sel == 0);
  assign if4.rd_x = rx[1:0];
  assign if4.rd_y = ry[1:0];
  assign if1.start = start && (sel == 1);
  assign if1.start_x = sx[0];
  assign if1.start_y = sy[0];
  assign if1.rd_en = rdEn && (sel == 1);
  assign if1.rd_x = rx[0];
  assign if1.rd_y = ry[0];
  assign if8.start = start && (sel == 2);
  assign if8.start_x = sx;
  assign if8.start_y = sy;
  assign if8.rd_en = rdEn && (sel == 2);
  assign if8.rd_x = rx;
  assign if8.rd_y = ry;

  always_comb begin
    case (sel)
      0:       begin busyS = if4.busy; doneS = if4.done; rdValidS = if4.rd_valid; rdDataS = if4.rd_data; end
      1:       begin busyS = if1.busy; doneS = if1.done; rdValidS = if1.rd_valid; rdDataS = if1.rd_data; end
      default: begin busyS = if8.busy; doneS = if8.done; rdValidS = if8.rd_valid; rdDataS = if8.rd_data; end
    endcase
  end

`ifdef MAZE_STATS_EN
  logic [31:0] maxS, stepS;
  always_comb begin
    case (sel)
      0:       begin maxS = 32'(if4.max_depth); stepS = if4.step_count; end
      1:       begin maxS = 32'(if1.max_depth); stepS = if1.step_count; end
      default: begin maxS = 32'(if8.max_depth); stepS = if8.step_count; end
    endcase
  end
`endif

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference recursive backtracker, stepping the LFSR once per modelled busy cycle.
  task automatic runModel(input int w, input int h, input int sx0, input int sy0);
    int n, sp, c, nx, ny, dir;
    int stkX [64];
    int stkY [64];
    bit vis [64];
    logic [3:0] m;
    logic [15:0] l;
    l = mdlL[sel];
    n = w * h;
    expE = '0; expS = '0; expCyc = 0; expSteps = 0;
    for (int i = 0; i < 64; i++) vis[i] = 1'b0;
    repeat (n) begin l = lfsrNext(l); expCyc++; end
    if (sx0 >= w || sy0 >= h) begin sx0 = 0; sy0 = 0; end
    vis[sy0 * w + sx0] = 1'b1;
    stkX[0] = sx0; stkY[0] = sy0; sp = 1; expMax = 1;
    l = lfsrNext(l); expCyc++;
    while (sp > 0) begin
      nx = stkX[sp-1]; ny = stkY[sp-1]; c = ny * w + nx;
      m = 4'b0000;
      if (nx < w - 1 && !vis[c+1]) m[0] = 1'b1;
      if (nx > 0 && !vis[c-1])     m[1] = 1'b1;
      if (ny < h - 1 && !vis[c+w]) m[2] = 1'b1;
      if (ny > 0 && !vis[c-w])     m[3] = 1'b1;
      l = lfsrNext(l); expCyc++; expSteps++;
      if (m != 4'b0000) begin
        dir = int'(l[1:0]);
        while (!m[dir]) dir = (dir + 1) % 4;
        case (dir)
          0: begin expE[c] = 1'b1;   nx = nx + 1; end
          1: begin expE[c-1] = 1'b1; nx = nx - 1; end
          2: begin expS[c] = 1'b1;   ny = ny + 1; end
          default: begin expS[c-w] = 1'b1; ny = ny - 1; end
        endcase
        vis[ny * w + nx] = 1'b1;
        stkX[sp] = nx; stkY[sp] = ny; sp++;
        if (sp > expMax) expMax = sp;
      end else begin
        sp--;
      end
      l = lfsrNext(l);
      if (m != 4'b0000) begin expCyc++; expSteps++; end else begin expCyc++; expSteps++; end
    end
    mdlL[sel] = l;
  endtask

  task automatic applyStimulus(input int x, input int y);
    start = 1'b1; sx = 3'(x); sy = 3'(y);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int c);
    c = 0;
    while (!doneS && c < budget) begin @(posedge clk); #1; c++; end
    if (!doneS) checkOutput("done_timeout", doneS, 1);
  endtask

  task automatic readCell(input int x, input int y, output logic [1:0] dd, output logic vv);
    rdEn = 1'b1; rx = 3'(x); ry = 3'(y);
    @(posedge clk); #1;
    rdEn = 1'b0;
    dd = rdDataS; vv = rdValidS;
  endtask

  task automatic readMaze(input int w, input int h);
    logic [1:0] dd;
    logic vv, allValid;
    allValid = 1'b1; gotE = '0; gotS = '0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        readCell(x, y, dd, vv);
        allValid = allValid & vv;
        gotE[y*w+x] = dd[1];
        gotS[y*w+x] = dd[0];
      end
    checkOutput("rd_valid_all", allValid, 1);
  endtask

  task automatic checkMaze(input string tag, input int w, input int h);
    int q [64];
    bit seen [64];
    int head, tail, c, bad;
    checkOutput({tag, "_east"}, gotE, expE);
    checkOutput({tag, "_south"}, gotS, expS);
    checkOutput({tag, "_opens"}, $countones(gotE) + $countones(gotS), w * h - 1);
    bad = 0;
    for (int i = 0; i < w * h; i++) begin
      seen[i] = 1'b0;
      if ((i % w) == w - 1 && gotE[i]) bad++;
      if ((i / w) == h - 1 && gotS[i]) bad++;
    end
    checkOutput({tag, "_edge_walls"}, bad, 0);
    head = 0; tail = 1; q[0] = 0; seen[0] = 1'b1;
    while (head < tail) begin
      c = q[head]; head++;
      if ((c % w) < w - 1 && gotE[c] && !seen[c+1])  begin seen[c+1] = 1'b1; q[tail] = c + 1; tail++; end
      if ((c % w) > 0 && gotE[c-1] && !seen[c-1])    begin seen[c-1] = 1'b1; q[tail] = c - 1; tail++; end
      if ((c / w) < h - 1 && gotS[c] && !seen[c+w])  begin seen[c+w] = 1'b1; q[tail] = c + w; tail++; end
      if ((c / w) > 0 && gotS[c-w] && !seen[c-w])    begin seen[c-w] = 1'b1; q[tail] = c - w; tail++; end
    end
    checkOutput({tag, "_reach"}, tail, w * h);
  endtask

  task automatic checkStats(input string tag);
`ifdef MAZE_STATS_EN
    checkOutput({tag, "_max_depth"}, maxS, expMax);
    checkOutput({tag, "_step_count"}, stepS, expSteps);
`else
    $display("[TB] %s: statistics outputs not built", tag);
`endif
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; sel = 0; start = 1'b0; rdEn = 1'b0;
    sx = '0; sy = '0; rx = '0; ry = '0;
    for (int i = 0; i < 3; i++) mdlL[i] = 16'hACE1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busyS, 0);
    checkOutput("rst_done", doneS, 0);
    checkOutput("rst_rd_valid", rdValidS, 0);
    checkOutput("rst_rd_data", rdDataS, 0);
    reset = 1'b0;

    $display("[TB] 4x4 run A from (0,0)");
    applyStimulus(0, 0);
    checkOutput("a_busy", busyS, 1);
    checkOutput("a_done_low", doneS, 0);
    waitDone(5000, cyc);
    runModel(4, 4, 0, 0);
    checkOutput("a_cycles", cyc, expCyc);
    checkOutput("a_busy_end", busyS, 0);
    checkStats("a");
    readMaze(4, 4);
    checkMaze("a", 4, 4);
    saveE = gotE; saveS = gotS;
    checkOutput("a_start_cell_open", gotE[0] | gotS[0], 1);

    $display("[TB] 4x4 run B restarted from DONE, reads and start while busy");
    applyStimulus(0, 0);
    readCell(0, 0, d, v);
    checkOutput("b_busy_read00_valid", v, 1);
    checkOutput("b_busy_read00_data", d, 0);
    readCell(1, 1, d, v);
    checkOutput("b_busy_read11_valid", v, 1);
    checkOutput("b_busy_read11_data", d, 0);
    applyStimulus(2, 2);
    checkOutput("b_busy_after_start", busyS, 1);
    waitDone(5000, cyc);
    runModel(4, 4, 0, 0);
    checkOutput("b_cycles", cyc + 3, expCyc);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("b_done_held", doneS, 1);
    checkOutput("b_busy_held", busyS, 0);
    readMaze(4, 4);
    checkMaze("b", 4, 4);
    checkOutput("b_differs", {gotE, gotS} != {saveE, saveS}, 1);

    $display("[TB] 4x4 run C after reset");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mdlL[i] = 16'hACE1;
    applyStimulus(0, 0);
    waitDone(5000, cyc);
    runModel(4, 4, 0, 0);
    checkOutput("c_cycles", cyc, expCyc);
    readMaze(4, 4);
    checkMaze("c", 4, 4);
    checkOutput("c_same_east", gotE, saveE);
    checkOutput("c_same_south", gotS, saveS);

    $display("[TB] 1x1 grid");
    sel = 1;
    applyStimulus(0, 0);
    checkOutput("u_busy", busyS, 1);
    waitDone(100, cyc);
    checkOutput("u_cycles", cyc, 4);
    runModel(1, 1, 0, 0);
    checkStats("u");
    readCell(0, 0, d, v);
    checkOutput("u_read_valid", v, 1);
    checkOutput("u_read_data", d, 0);
    applyStimulus(1, 1);
    waitDone(100, cyc);
    checkOutput("u_oor_start_cycles", cyc, 4);
    runModel(1, 1, 1, 1);
    checkStats("u_oor");
    readCell(1, 0, d, v);
    checkOutput("u_oor_read_valid", v, 1);
    checkOutput("u_oor_read_data", d, 0);

    $display("[TB] 8x8 reset mid-generation then full run");
    sel = 2;
    applyStimulus(0, 0);
    repeat (64 + 1 + 7) @(posedge clk);
    #1;
    checkOutput("r_busy_before_reset", busyS, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("r_busy_after_reset", busyS, 0);
    checkOutput("r_done_after_reset", doneS, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mdlL[i] = 16'hACE1;
    applyStimulus(3, 5);
    waitDone(5000, cyc);
    runModel(8, 8, 3, 5);
    checkOutput("r_cycles", cyc, expCyc);
    checkStats("r");
    readMaze(8, 8);
    checkMaze("r", 8, 8);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
